// File: rtl/caster_pkg.sv
// ---------------------------------------------------------------------------
// caster_pkg
//   Shared types and constants for the MultiCaster upstream dispatcher.
//   - disp_state_t : dispatcher FSM states
//   - EN_*         : bit positions of the {psum,fltr,ifmap} caster enable
//   - DATA_WIDTH / NUM_COL : default operand width and caster column count
// ---------------------------------------------------------------------------
package caster_pkg;

   localparam int DATA_WIDTH = 16;
   localparam int NUM_COL    = 4;

   localparam int EN_IFMAP = 0;
   localparam int EN_FLTR  = 1;
   localparam int EN_PSUM  = 2;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      ISSUE = 3'd2,
      WAIT  = 3'd3,
      DRAIN = 3'd4
   } disp_state_t;

endpackage

// File: rtl/operand_slot.sv
// ---------------------------------------------------------------------------
// operand_slot
//   One-entry holding register for an operand stream.
//   Ports:
//     clk, rstn      clock / async active-low reset
//     en_i           slot may accept data (dispatcher busy)
//     valid_i        upstream valid
//     data_i         upstream data (W bits)
//     clear_i        empty the slot (operand consumed by the casters)
//     ready_o        upstream ready = empty && en_i
//     full_o         slot holds a valid operand
//     data_o         held operand, always visible
// ---------------------------------------------------------------------------
module operand_slot #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         en_i,
   input  logic         valid_i,
   input  logic [W-1:0] data_i,
   input  logic         clear_i,
   output logic         ready_o,
   output logic         full_o,
   output logic [W-1:0] data_o
);

   logic         full_q, full_d;
   logic [W-1:0] data_q, data_d;

   assign ready_o = !full_q && en_i;
   assign full_o  = full_q;
   assign data_o  = data_q;

   // clear only ever arrives while the slot is full, so it never collides
   // with a capture; clear is still given priority.
   always_comb begin
      full_d = full_q;
      data_d = data_q;
      if (clear_i) begin
         full_d = 1'b0;
      end else if (valid_i && ready_o) begin
         full_d = 1'b1;
         data_d = data_i;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         full_q <= 1'b0;
         data_q <= '0;
      end else begin
         full_q <= full_d;
         data_q <= data_d;
      end
   end

endmodule

// File: rtl/caster_dispatcher.sv
// ---------------------------------------------------------------------------
// caster_dispatcher
//   Gathers one {ifmap, fltr, psum} operand triple from the global buffer,
//   issues it to the MultiCaster, waits for the result and returns the
//   updated psum to the buffer. Repeats for job_len_i ops.
//   Ports:
//     clk, rstn                      clock / async active-low reset
//     job_start_i, job_len_i         job launch (sampled in IDLE only)
//     busy_o, done_o                 job in progress / one-cycle end pulse
//     ifmap_*, fltr_*, psum_*        operand streams in (valid/ready/data)
//     out_valid_o/out_ready_i/out_data_o  psum result stream out
//     caster_en_o                    {psum,fltr,ifmap} enable to casters
//     ifmap_b2m_o/fltr_b2m_o/psum_b2m_o   operand data to casters
//     caster_ready_i, caster_valid_i, psum_m2b_i   caster handshake/result
// ---------------------------------------------------------------------------
module caster_dispatcher
   import caster_pkg::*;
#(
   parameter int DATA_WIDTH = caster_pkg::DATA_WIDTH,
   parameter int NUM_COL    = caster_pkg::NUM_COL,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    job_start_i,
   input  logic [CNT_WIDTH-1:0]    job_len_i,
   output logic                    busy_o,
   output logic                    done_o,
   input  logic                    ifmap_valid_i,
   output logic                    ifmap_ready_o,
   input  logic [DATA_WIDTH-1:0]   ifmap_data_i,
   input  logic                    fltr_valid_i,
   output logic                    fltr_ready_o,
   input  logic [DATA_WIDTH-1:0]   fltr_data_i,
   input  logic                    psum_valid_i,
   output logic                    psum_ready_o,
   input  logic [2*DATA_WIDTH-1:0] psum_data_i,
   output logic                    out_valid_o,
   input  logic                    out_ready_i,
   output logic [2*DATA_WIDTH-1:0] out_data_o,
   output logic [2:0]              caster_en_o,
   output logic [DATA_WIDTH-1:0]   ifmap_b2m_o,
   output logic [DATA_WIDTH-1:0]   fltr_b2m_o,
   output logic [2*DATA_WIDTH-1:0] psum_b2m_o,
   input  logic                    caster_ready_i,
   input  logic                    caster_valid_i,
   input  logic [2*DATA_WIDTH-1:0] psum_m2b_i
);

   // NUM_COL is informational here; the datapath is column-agnostic.
   if (NUM_COL < 1) begin : g_no_cols
   end

   disp_state_t             state_q, state_d;
   logic [CNT_WIDTH-1:0]    rem_q, rem_d;
   logic [2*DATA_WIDTH-1:0] result_q, result_d;
   logic                    done_q, done_d;

   logic slot_en, slot_clr;
   logic ifmap_full, fltr_full, psum_full, all_full;

   assign slot_en  = (state_q != IDLE);
   assign all_full = ifmap_full && fltr_full && psum_full;

   operand_slot #(.W(DATA_WIDTH)) u_ifmap_slot (
      .clk     (clk),
      .rstn    (rstn),
      .en_i    (slot_en),
      .valid_i (ifmap_valid_i),
      .data_i  (ifmap_data_i),
      .clear_i (slot_clr),
      .ready_o (ifmap_ready_o),
      .full_o  (ifmap_full),
      .data_o  (ifmap_b2m_o)
   );

   operand_slot #(.W(DATA_WIDTH)) u_fltr_slot (
      .clk     (clk),
      .rstn    (rstn),
      .en_i    (slot_en),
      .valid_i (fltr_valid_i),
      .data_i  (fltr_data_i),
      .clear_i (slot_clr),
      .ready_o (fltr_ready_o),
      .full_o  (fltr_full),
      .data_o  (fltr_b2m_o)
   );

   operand_slot #(.W(2*DATA_WIDTH)) u_psum_slot (
      .clk     (clk),
      .rstn    (rstn),
      .en_i    (slot_en),
      .valid_i (psum_valid_i),
      .data_i  (psum_data_i),
      .clear_i (slot_clr),
      .ready_o (psum_ready_o),
      .full_o  (psum_full),
      .data_o  (psum_b2m_o)
   );

   always_comb begin
      state_d  = state_q;
      rem_d    = rem_q;
      result_d = result_q;
      done_d   = 1'b0;
      slot_clr = 1'b0;
      case (state_q)
         IDLE: begin
            if (job_start_i) begin
               rem_d = job_len_i;
               if (job_len_i == '0) done_d  = 1'b1;
               else                 state_d = LOAD;
            end
         end
         // full flags are registered, so ISSUE starts the cycle after the
         // last operand lands
         LOAD: begin
            if (all_full) state_d = ISSUE;
         end
         ISSUE: begin
            if (caster_ready_i) begin
               slot_clr = 1'b1;
               state_d  = WAIT;
            end
         end
         WAIT: begin
            if (caster_valid_i) begin
               result_d = psum_m2b_i;
               state_d  = DRAIN;
            end
         end
         DRAIN: begin
            if (out_ready_i) begin
               rem_d = rem_q - 1'b1;
               if (rem_q == CNT_WIDTH'(1)) begin
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else if (all_full) begin
                  // next triple was prefetched during WAIT/DRAIN
                  state_d = ISSUE;
               end else begin
                  state_d = LOAD;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= IDLE;
         rem_q    <= '0;
         result_q <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         rem_q    <= rem_d;
         result_q <= result_d;
         done_q   <= done_d;
      end
   end

   assign busy_o      = (state_q != IDLE);
   assign done_o      = done_q;
   assign out_valid_o = (state_q == DRAIN);
   assign out_data_o  = result_q;

   always_comb begin
      caster_en_o = 3'b000;
      if (state_q == ISSUE) begin
         caster_en_o[EN_IFMAP] = 1'b1;
         caster_en_o[EN_FLTR]  = 1'b1;
         caster_en_o[EN_PSUM]  = 1'b1;
      end
   end

endmodule
